inert_intf: RTL and testbench

- Sequences the inertial sensor over an external 16-bit SPI master and feeds the inertial integrator.
- After a power-up delay, writes four sensor configuration registers once.
- On each sensor data-ready interrupt, performs four 16-bit SPI reads (pitch-rate low/high, AZ low/high).
- Presents assembled `ptch_rt`/`AZ` with a one-cycle `vld` pulse to the integrator.

---
 rtl/inert_intf_pkg.sv | 17 +
 rtl/inert_intf.sv | 107 ++++++++++
 tb/tb_inert_intf.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/inert_intf_pkg.sv
// Shared types and SPI command words for the inertial sensor sequencer.
package inert_pkg;

   typedef enum logic [3:0] {
      INIT1, INIT2, INIT3, INIT4, INITW, WAIT, PL, PH, ZL, ZH
   } state_t;

   localparam logic [15:0] CMD_INT_EN    = 16'h0D02;
   localparam logic [15:0] CMD_ACCEL_CFG = 16'h1053;
   localparam logic [15:0] CMD_GYRO_CFG  = 16'h1150;
   localparam logic [15:0] CMD_ROUND     = 16'h1460;
   localparam logic [15:0] CMD_RD_PTCHL  = 16'hA200;
   localparam logic [15:0] CMD_RD_PTCHH  = 16'hA300;
   localparam logic [15:0] CMD_RD_AZL    = 16'hAC00;
   localparam logic [15:0] CMD_RD_AZH    = 16'hAD00;

endpackage

// File: rtl/inert_intf.sv
// Inertial sensor sequencer: one-shot config writes, then a 4-read burst per
// data-ready interrupt, presenting pitch rate and AZ to the integrator.
module inert_intf
   import inert_pkg::*;
#(
   parameter int INIT_WAIT_BITS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic        vld,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ
);

   logic [INIT_WAIT_BITS-1:0] timer;
   logic                      ff1, ff2, ff3;
   logic                      int_evt;
   state_t                    state;
   logic [7:0]                ptch_l, ptch_h, az_l;
   logic                      unused_hi;

   // sensor returns register contents in the low byte only
   assign unused_hi = ^rd_data[15:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         timer <= '0;
      else if (!(&timer))
         timer <= timer + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1 <= 1'b0;
         ff2 <= 1'b0;
         ff3 <= 1'b0;
      end else begin
         ff1 <= INT;
         ff2 <= ff1;
         ff3 <= ff2;
      end
   end

   assign int_evt = ff2 & ~ff3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= INIT1;
         wrt     <= 1'b0;
         cmd     <= 16'h0000;
         vld     <= 1'b0;
         ptch_rt <= 16'h0000;
         AZ      <= 16'h0000;
         ptch_l  <= 8'h00;
         ptch_h  <= 8'h00;
         az_l    <= 8'h00;
      end else begin
         wrt <= 1'b0;
         vld <= 1'b0;
         case (state)
            INIT1: if (&timer) begin
               wrt <= 1'b1; cmd <= CMD_INT_EN; state <= INIT2;
            end
            INIT2: if (done) begin
               wrt <= 1'b1; cmd <= CMD_ACCEL_CFG; state <= INIT3;
            end
            INIT3: if (done) begin
               wrt <= 1'b1; cmd <= CMD_GYRO_CFG; state <= INIT4;
            end
            INIT4: if (done) begin
               wrt <= 1'b1; cmd <= CMD_ROUND; state <= INITW;
            end
            INITW: if (done) state <= WAIT;
            // interrupts seen in any other state are dropped, not queued
            WAIT: if (int_evt) begin
               wrt <= 1'b1; cmd <= CMD_RD_PTCHL; state <= PL;
            end
            PL: if (done) begin
               ptch_l <= rd_data[7:0];
               wrt <= 1'b1; cmd <= CMD_RD_PTCHH; state <= PH;
            end
            PH: if (done) begin
               ptch_h <= rd_data[7:0];
               wrt <= 1'b1; cmd <= CMD_RD_AZL; state <= ZL;
            end
            ZL: if (done) begin
               az_l <= rd_data[7:0];
               wrt <= 1'b1; cmd <= CMD_RD_AZH; state <= ZH;
            end
            // both outputs update on the same edge so the integrator never sees a torn sample
            ZH: if (done) begin
               ptch_rt <= {ptch_h, ptch_l};
               AZ      <= {rd_data[7:0], az_l};
               vld     <= 1'b1;
               state   <= WAIT;
            end
            default: state <= INIT1;
         endcase
      end
   end

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf with a behavioural SPI master responder.
module tb_inert_intf;

   localparam int IW = 8;

   logic        clk, rst_n, INT, done;
   logic [15:0] rd_data;
   logic        wrt, vld;
   logic [15:0] cmd, ptch_rt, AZ;

   int          n_cmp = 0, n_err = 0;
   int          n_wrt = 0, n_vld = 0, bad_chg = 0;
   int          cyc = 0, done_cyc = 0, vld_cyc = 0;
   logic        pending = 0, lat_rand = 0;
   logic [15:0] pend_cmd;
   logic [31:0] prev_out = 0;
   logic [15:0] cmd_log[$];
   logic [7:0]  rd_q[$];

   inert_intf #(.INIT_WAIT_BITS(IW)) dut (
      .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
      .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SPI master model: answers each wrt with done after a latency, checks handshake meanwhile
   initial begin : spi_model
      int   lat;
      logic skip;
      logic [7:0] b;
      done = 0; rd_data = 16'h0000;
      forever begin
         @(negedge clk);
         while (wrt) begin
            n_wrt++; cmd_log.push_back(cmd); pend_cmd = cmd; pending = 1; skip = 0;
            lat = lat_rand ? int'($urandom_range(200, 1)) : 40;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               if (!rst_n) skip = 1;
               if (!skip) begin
                  chk("wrt_while_pending", {31'd0, wrt}, 32'd0);
                  chk("cmd_stable", {16'd0, cmd}, {16'd0, pend_cmd});
               end
            end
            b = 8'h00;
            if (rd_q.size() > 0) b = rd_q.pop_front();
            done = 1; rd_data = {8'hA5, b}; done_cyc = cyc;
            @(negedge clk);
            done = 0; pending = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (vld) begin n_vld++; vld_cyc = cyc; end
      if (rst_n && {ptch_rt, AZ} != prev_out && !vld) bad_chg++;
      prev_out = {ptch_rt, AZ};
   end

   task automatic wait_vld(input int target);
      int k = 0;
      while (n_vld < target && k < 3000) begin @(negedge clk); k++; end
      chk("vld_count", n_vld, target);
   endtask

   task automatic wait_wrt(input int target);
      int k = 0;
      while (n_wrt < target && k < 3000) begin @(negedge clk); k++; end
      chk("wrt_count", n_wrt, target);
   endtask

   task automatic wait_idle(input int extra);
      int k = 0;
      while (pending && k < 3000) begin @(negedge clk); k++; end
      repeat (extra) @(negedge clk);
   endtask

   task automatic pulse_int();
      INT = 1; repeat (3) @(negedge clk); INT = 0;
   endtask

   task automatic push4(input logic [7:0] a, b, c, d);
      rd_q.push_back(a); rd_q.push_back(b); rd_q.push_back(c); rd_q.push_back(d);
   endtask

   initial begin : main
      int cnt;
      rst_n = 0; INT = 0;
      repeat (3) @(negedge clk);
      chk("rst_wrt", {31'd0, wrt}, 0);
      chk("rst_cmd", {16'd0, cmd}, 0);
      chk("rst_vld", {31'd0, vld}, 0);
      chk("rst_ptch", {16'd0, ptch_rt}, 0);
      chk("rst_az", {16'd0, AZ}, 0);

      // power-up: first wrt once the timer has saturated
      rst_n = 1; cnt = 0;
      while (!wrt && cnt < 600) begin @(negedge clk); cnt++; end
      chk("first_wrt_time", {31'd0, (cnt == 255 || cnt == 256)}, 1);
      repeat (2) @(negedge clk);
      pulse_int();  // during init: must be dropped
      wait_wrt(4);
      wait_idle(60);
      chk("init_wrt_total", n_wrt, 4);
      chk("init_cmd0", {16'd0, cmd_log[0]}, 32'h0D02);
      chk("init_cmd1", {16'd0, cmd_log[1]}, 32'h1053);
      chk("init_cmd2", {16'd0, cmd_log[2]}, 32'h1150);
      chk("init_cmd3", {16'd0, cmd_log[3]}, 32'h1460);
      chk("init_no_vld", n_vld, 0);

      // first read burst
      push4(8'hC2, 8'h13, 8'h00, 8'h08);
      pulse_int();
      wait_vld(1);
      chk("rd_cmd0", {16'd0, cmd_log[4]}, 32'hA200);
      chk("rd_cmd1", {16'd0, cmd_log[5]}, 32'hA300);
      chk("rd_cmd2", {16'd0, cmd_log[6]}, 32'hAC00);
      chk("rd_cmd3", {16'd0, cmd_log[7]}, 32'hAD00);
      chk("burst1_ptch", {16'd0, ptch_rt}, 32'h13C2);
      chk("burst1_az", {16'd0, AZ}, 32'h0800);
      chk("vld_latency", vld_cyc - done_cyc, 1);
      repeat (3) @(negedge clk);
      chk("vld_one_cycle", n_vld, 1);

      // INT held high: exactly one burst
      push4(8'h11, 8'h22, 8'h33, 8'h44);
      INT = 1;
      repeat (500) @(negedge clk);
      chk("hold_wrt_total", n_wrt, 12);
      chk("hold_vld_total", n_vld, 2);
      chk("hold_ptch", {16'd0, ptch_rt}, 32'h2211);
      chk("hold_az", {16'd0, AZ}, 32'h4433);
      INT = 0; repeat (5) @(negedge clk);
      push4(8'h00, 8'h10, 8'hFF, 8'hFF);
      INT = 1;
      wait_vld(3);
      chk("repeat_ptch", {16'd0, ptch_rt}, 32'h1000);
      chk("repeat_az", {16'd0, AZ}, 32'hFFFF);
      INT = 0; wait_idle(10);

      // second edge during PH is dropped
      push4(8'h01, 8'h02, 8'h03, 8'h04);
      pulse_int();
      wait_wrt(18);
      repeat (3) @(negedge clk);
      pulse_int();
      wait_vld(4);
      repeat (100) @(negedge clk);
      chk("drop_wrt_total", n_wrt, 20);
      chk("drop_vld_total", n_vld, 4);
      chk("drop_ptch", {16'd0, ptch_rt}, 32'h0201);
      chk("drop_az", {16'd0, AZ}, 32'h0403);
      push4(8'h05, 8'h06, 8'h07, 8'h08);
      pulse_int();
      wait_vld(5);
      chk("next_ptch", {16'd0, ptch_rt}, 32'h0605);
      chk("next_az", {16'd0, AZ}, 32'h0807);
      wait_idle(10);

      // reset in the middle of the AZ-low read
      push4(8'h55, 8'h66, 8'h77, 8'h88);
      pulse_int();
      wait_wrt(27);
      repeat (5) @(negedge clk);
      rst_n = 0; #1;
      chk("midrst_wrt", {31'd0, wrt}, 0);
      chk("midrst_cmd", {16'd0, cmd}, 0);
      chk("midrst_vld", {31'd0, vld}, 0);
      chk("midrst_ptch", {16'd0, ptch_rt}, 0);
      chk("midrst_az", {16'd0, AZ}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1; rd_q.delete();
      wait_idle(0);
      chk("stray_done_ignored", n_wrt, 27);
      wait_wrt(31);
      chk("reinit_cmd0", {16'd0, cmd_log[27]}, 32'h0D02);
      chk("reinit_cmd3", {16'd0, cmd_log[30]}, 32'h1460);
      wait_idle(20);
      chk("reinit_no_vld", n_vld, 5);
      chk("reinit_ptch", {16'd0, ptch_rt}, 0);

      // random done latency
      lat_rand = 1;
      push4(8'h9A, 8'h78, 8'h56, 8'h34);
      pulse_int();
      wait_vld(6);
      chk("rand1_ptch", {16'd0, ptch_rt}, 32'h789A);
      chk("rand1_az", {16'd0, AZ}, 32'h3456);
      wait_idle(5);
      push4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
      pulse_int();
      wait_vld(7);
      chk("rand2_ptch", {16'd0, ptch_rt}, 32'hBEEF);
      chk("rand2_az", {16'd0, AZ}, 32'hDEAD);
      wait_idle(5);
      chk("rand_wrt_total", n_wrt, 39);

      chk("no_torn_update", bad_chg, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
